// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the five-stage ARM pipeline.
//
// Holds the PC, issues word fetches over a req/ack instruction-memory
// handshake (one outstanding request, arbitrary wait states) and owns the
// IF/ID pipeline register feeding decode.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   freeze                   decode hazard stall; IF/ID must hold
//   branch_taken/branch_addr one-cycle redirect from execute
//   imem_req/imem_addr       fetch request (Moore, from registered state)
//   imem_ack/imem_rdata      one-cycle response strobe and instruction word
//   valid/pc_out/instruction IF/ID register (pc_out = fetch address + 4)
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        valid,
    output logic [31:0] pc_out,
    output logic [31:0] instruction
);

    typedef enum logic [1:0] {FETCH, STALL, SQUASH} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] req_addr, req_addr_nxt;
    logic [31:0] skid_instr, skid_instr_nxt;
    logic [31:0] skid_pc, skid_pc_nxt;
    logic        valid_nxt;
    logic [31:0] pc_out_nxt, instruction_nxt;

    logic [31:0] pc_inc;
    logic [31:0] target;

    assign pc_inc = pc + 32'd4;
    assign target = {branch_addr[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            req_addr    <= '0;
            skid_instr  <= '0;
            skid_pc     <= '0;
            valid       <= 1'b0;
            pc_out      <= '0;
            instruction <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            req_addr    <= req_addr_nxt;
            skid_instr  <= skid_instr_nxt;
            skid_pc     <= skid_pc_nxt;
            valid       <= valid_nxt;
            pc_out      <= pc_out_nxt;
            instruction <= instruction_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        req_addr_nxt    = req_addr;
        skid_instr_nxt  = skid_instr;
        skid_pc_nxt     = skid_pc;
        valid_nxt       = valid;
        pc_out_nxt      = pc_out;
        instruction_nxt = instruction;
        // Request outputs depend on state only, so no input reaches them.
        imem_req        = (state != STALL);
        imem_addr       = (state == SQUASH) ? req_addr : pc;

        case (state)
            FETCH: begin
                if (branch_taken) begin
                    valid_nxt = 1'b0;
                    pc_nxt    = target;
                    // An unacked request cannot be withdrawn; remember its
                    // address and drain it before fetching the target.
                    if (!imem_ack) begin
                        req_addr_nxt = pc;
                        state_nxt    = SQUASH;
                    end
                end else if (imem_ack) begin
                    pc_nxt = pc_inc;
                    if (!freeze || !valid) begin
                        valid_nxt       = 1'b1;
                        pc_out_nxt      = pc_inc;
                        instruction_nxt = imem_rdata;
                    end else begin
                        // IF/ID is frozen with a live word: park the new one.
                        skid_instr_nxt = imem_rdata;
                        skid_pc_nxt    = pc_inc;
                        state_nxt      = STALL;
                    end
                end else if (!freeze) begin
                    valid_nxt = 1'b0;
                end
            end

            STALL: begin
                if (branch_taken) begin
                    valid_nxt = 1'b0;
                    pc_nxt    = target;
                    state_nxt = FETCH;
                end else if (!freeze) begin
                    valid_nxt       = 1'b1;
                    pc_out_nxt      = skid_pc;
                    instruction_nxt = skid_instr;
                    state_nxt       = FETCH;
                end
            end

            SQUASH: begin
                // IF/ID is already flushed; the drained word is dropped.
                valid_nxt = 1'b0;
                if (branch_taken) begin
                    pc_nxt = target;
                end else if (imem_ack) begin
                    state_nxt = FETCH;
                end
            end

            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- randomized self-checking bench for if_stage.
//
// The driver plays the instruction memory (random wait states and data),
// decode (random freeze) and execute (random redirects). It keeps a
// transaction-level model: the next expected fetch address, and whether a
// pending memory response must be thrown away after a redirect. Every word
// that should reach decode is pushed on exp_q. The monitor consumes exp_q
// whenever decode takes an instruction (valid && !freeze), flushes it on a
// redirect, and compares the IF/ID register against the queue head.
// ---------------------------------------------------------------------------
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        valid;
    logic [31:0] pc_out;
    logic [31:0] instruction;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .branch_taken(branch_taken),
        .branch_addr (branch_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .valid       (valid),
        .pc_out      (pc_out),
        .instruction (instruction)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   run = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        case ($urandom_range(3))
            0:       t = $urandom_range(255);
            1:       t = 32'hFFFF_FFF0 | $urandom_range(15);
            default: t = $urandom;
        endcase
        return t;
    endfunction

    // Monitor: inputs seen here still belong to the cycle that just ended,
    // since the driver updates them 1 time unit after this edge.
    initial begin
        logic        lv;
        logic [31:0] lpc;
        logic [31:0] linstr;
        exp_t        e;
        lv = 1'b0;
        lpc = '0;
        linstr = '0;
        forever begin
            @(negedge clk);
            if (run) begin
                if (lv && !freeze) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL consume_unexpected actual_pc=%h expected=none", lpc);
                    end else begin
                        e = exp_q.pop_front();
                        check32("consume_pc", lpc, e.pc);
                        check32("consume_instr", linstr, e.instr);
                    end
                end
                if (branch_taken) exp_q.delete();
                check32("valid", 32'(valid), 32'(exp_q.size() != 0));
                if (valid && exp_q.size() != 0) begin
                    check32("ifid_pc", pc_out, exp_q[0].pc);
                    check32("ifid_instr", instruction, exp_q[0].instr);
                end
                lv = valid;
                lpc = pc_out;
                linstr = instruction;
            end
        end
    end

    // Driver + memory + reference model.
    initial begin
        bit          busy;
        bit          debt;
        bit          ack_v;
        bit          br;
        logic [31:0] paddr;
        logic [31:0] model_pc;
        exp_t        e;
        int          wl;
        int          max_wait;
        int          fr_pct;
        int          br_pct;

        busy = 1'b0;
        debt = 1'b0;
        paddr = '0;
        wl = 0;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check32("rst_req", 32'(imem_req), 32'd1);
        check32("rst_addr", imem_addr, 32'h0);
        check32("rst_valid", 32'(valid), 32'd0);
        check32("rst_pc_out", pc_out, 32'h0);
        check32("rst_instr", instruction, 32'h0);

        rst = 1'b1;
        @(negedge clk);
        check32("rel_req", 32'(imem_req), 32'd1);
        check32("rel_addr", imem_addr, 32'h0);
        check32("rel_valid", 32'(valid), 32'd0);
        check32("rel_pc_out", pc_out, 32'h0);

        model_pc = 32'h0;
        run = 1'b1;
        for (int ph = 0; ph < 5; ph++) begin
            case (ph)
                0:       begin max_wait = 0; fr_pct = 0;  br_pct = 0;  end
                1:       begin max_wait = 3; fr_pct = 0;  br_pct = 0;  end
                2:       begin max_wait = 2; fr_pct = 40; br_pct = 0;  end
                3:       begin max_wait = 3; fr_pct = 30; br_pct = 8;  end
                default: begin max_wait = 0; fr_pct = 35; br_pct = 12; end
            endcase
            for (int c = 0; c < 400; c++) begin
                #1;
                freeze = ($urandom_range(99) < fr_pct);
                br = ($urandom_range(99) < br_pct);
                branch_taken = br;
                branch_addr = br ? rand_target() : $urandom;

                ack_v = 1'b0;
                if (imem_req) begin
                    if (!busy) begin
                        busy = 1'b1;
                        paddr = imem_addr;
                        wl = $urandom_range(max_wait);
                        check32("addr_aligned", 32'(imem_addr[1:0]), 32'd0);
                    end else begin
                        check32("addr_stable", imem_addr, paddr);
                    end
                    if (wl == 0) begin
                        ack_v = 1'b1;
                        busy = 1'b0;
                    end else begin
                        wl--;
                    end
                end else if (busy) begin
                    checks++;
                    errors++;
                    $display("FAIL req_dropped actual=0 expected=1 addr=%h", paddr);
                    busy = 1'b0;
                end
                imem_ack = ack_v;
                imem_rdata = $urandom;

                // A response is delivered unless a redirect coincides with it
                // or it answers a request that was abandoned by a redirect.
                if (ack_v && !br && !debt) begin
                    check32("fetch_addr", paddr, model_pc);
                    e.pc = paddr + 32'd4;
                    e.instr = imem_rdata;
                    exp_q.push_back(e);
                    model_pc = model_pc + 32'd4;
                end
                debt = br ? (debt || (imem_req && !ack_v)) : (debt && !ack_v);
                if (br) model_pc = {branch_addr[31:2], 2'b00};

                @(negedge clk);
            end
        end
        #1;
        run = 1'b0;
        freeze = 1'b0;
        branch_taken = 1'b0;
        imem_ack = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
